// File: rtl/inst_fetcher_pkg.sv
// Shared fetch-side definitions: opcodes, queue depth, FSM states, entry layout.
package inst_fetcher_pkg;

  localparam int IQ_DEPTH_BIT = 4;
  localparam int ENTRY_W      = 65;

  localparam logic [6:0] CODE_JAL  = 7'b1101111;
  localparam logic [6:0] CODE_JALR = 7'b1100111;
  localparam logic [6:0] CODE_BR   = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        guess;
  } iq_entry_t;

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Static prediction: JAL always taken, conditional branches never taken.
  function automatic logic predict_taken(input logic [6:0] opcode);
    case (opcode)
      CODE_JAL: return 1'b1;
      CODE_BR:  return 1'b0;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Circular instruction queue with push/pop/clear; head is read combinationally.
module inst_fifo
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ENTRY_W-1:0]   din,
  output logic [ENTRY_W-1:0]   dout,
  output logic                 empty,
  output logic [DEPTH_BIT:0]   count
);

  localparam int DEPTH = 1 << DEPTH_BIT;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [DEPTH_BIT-1:0] head;
  logic [DEPTH_BIT-1:0] tail;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + DEPTH_BIT'(1);
      if (pop)  head <= head + DEPTH_BIT'(1);
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_BIT + 1)'(1);
        2'b01:   count <= count - (DEPTH_BIT + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[head];
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: one outstanding memory read, queue to decoder.
// Handshakes: mem_req is a one-cycle request answered later by a one-cycle mem_valid; the queue head is consumed when dec_valid and dec_issue are both high.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int QUEUE_DEPTH_BIT = IQ_DEPTH_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic [31:0]              flush_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_inst,
  output logic                     dec_valid,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_inst,
  output logic                     dec_guess,
  input  logic                     dec_issue,
  output logic [1:0]               dbg_state,
  output logic [QUEUE_DEPTH_BIT:0] dbg_count
);

  fetch_state_e               state;
  logic [31:0]                fetch_pc;
  logic [QUEUE_DEPTH_BIT:0]   count;
  logic                       empty;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic                       clear;
  logic [ENTRY_W-1:0]         head_raw;
  iq_entry_t                  head;
  logic [6:0]                 opcode;

  assign opcode = mem_inst[6:0];
  assign full   = count[QUEUE_DEPTH_BIT];

  assign mem_req  = rdy_in && !rst_in && !flush_in && (state == ST_IDLE) && !full;
  assign mem_addr = fetch_pc;

  // Flush wins over any same-cycle push or pop.
  assign push  = rdy_in && !flush_in && (state == ST_WAIT) && mem_valid;
  assign pop   = rdy_in && !flush_in && !empty && dec_issue;
  assign clear = rdy_in && flush_in;

  inst_fifo #(.DEPTH_BIT(QUEUE_DEPTH_BIT)) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   ({fetch_pc, mem_inst, predict_taken(opcode)}),
    .dout  (head_raw),
    .empty (empty),
    .count (count)
  );

  assign head      = iq_entry_t'(head_raw);
  assign dec_valid = !empty;
  assign dec_pc    = empty ? 32'h0 : head.pc;
  assign dec_inst  = empty ? 32'h0 : head.inst;
  assign dec_guess = empty ? 1'b0  : head.guess;
  assign dbg_state = state;
  assign dbg_count = count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      fetch_pc <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        fetch_pc <= flush_pc;
        // A response arriving with the flush is already consumed, so nothing is left to drop.
        if ((state == ST_WAIT || state == ST_DROP) && !mem_valid) state <= ST_DROP;
        else                                                       state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (mem_req) state <= ST_WAIT;
          ST_WAIT: begin
            if (mem_valid) begin
              case (opcode)
                CODE_JAL: begin
                  fetch_pc <= fetch_pc + imm_j(mem_inst);
                  state    <= ST_IDLE;
                end
                CODE_JALR: state <= ST_STALL;
                default: begin
                  fetch_pc <= fetch_pc + 32'd4;
                  state    <= ST_IDLE;
                end
              endcase
            end
          end
          ST_STALL: state <= ST_STALL;
          ST_DROP:  if (mem_valid) state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: fixed-latency memory responder, reference fetch model and queue scoreboard.
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic [31:0] flush_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_inst;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_guess;
  logic        dec_issue;
  logic [1:0]  dbg_state;
  logic [4:0]  dbg_count;

  int total = 0;
  int bad   = 0;

  inst_fetcher #(.QUEUE_DEPTH_BIT(4)) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .flush_pc  (flush_pc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_inst  (mem_inst),
    .dec_valid (dec_valid),
    .dec_pc    (dec_pc),
    .dec_inst  (dec_inst),
    .dec_guess (dec_guess),
    .dec_issue (dec_issue),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory image and reference model ----------------
  logic [31:0]   image [logic [31:0]];
  logic [64:0]   exp_q [$];
  fetch_state_e  m_st      = ST_IDLE;
  logic [31:0]   m_pc      = 32'h0;
  logic [31:0]   resp_word = 32'h0;
  int            lat       = 0;
  logic          mem_hold  = 1'b0;
  int            req_seen  = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (image.exists(a)) return image[a];
    return NOP;
  endfunction

  function automatic logic [31:0] jal_off(input logic [31:0] w);
    logic [20:0] imm;
    imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    return {{11{imm[20]}}, imm};
  endfunction

  task automatic sb_sample();
    logic        exp_req;
    logic [6:0]  op;
    logic [64:0] head;
    if (rst_in) begin
      m_st = ST_IDLE;
      m_pc = 32'h0;
      exp_q.delete();
      lat = 0;
      req_seen = 0;
      total++;
      if (mem_req !== 1'b0) begin
        bad++; $display("FAIL sb_reset_req got=%b exp=0", mem_req);
      end
    end else begin
      total++;
      if (exp_q.size() == 0) begin
        if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_inst !== 32'h0 || dec_guess !== 1'b0) begin
          bad++;
          $display("FAIL sb_empty got=%b/%h/%h/%b exp=0/0/0/0", dec_valid, dec_pc, dec_inst, dec_guess);
        end
      end else begin
        head = exp_q[0];
        if (dec_valid !== 1'b1 || {dec_pc, dec_inst, dec_guess} !== head) begin
          bad++;
          $display("FAIL sb_head got=%b/%h/%h/%b exp=1/%h/%h/%b",
                   dec_valid, dec_pc, dec_inst, dec_guess, head[64:33], head[32:1], head[0]);
        end
      end
      total++;
      if (dbg_count !== 5'(exp_q.size())) begin
        bad++; $display("FAIL sb_count got=%0d exp=%0d", dbg_count, exp_q.size());
      end
      total++;
      if (dbg_state !== m_st) begin
        bad++; $display("FAIL sb_state got=%0d exp=%0d", dbg_state, m_st);
      end
      if (mem_req === 1'b1) req_seen++;
      if (!rdy_in) begin
        total++;
        if (mem_req !== 1'b0) begin
          bad++; $display("FAIL sb_rdy_req got=%b exp=0", mem_req);
        end
      end else begin
        exp_req = !flush_in && (m_st == ST_IDLE) && (exp_q.size() < DEPTH);
        total++;
        if (mem_req !== exp_req) begin
          bad++; $display("FAIL sb_req got=%b exp=%b", mem_req, exp_req);
        end
        if (exp_req) begin
          total++;
          if (mem_addr !== m_pc) begin
            bad++; $display("FAIL sb_addr got=%h exp=%h", mem_addr, m_pc);
          end
        end
        if (flush_in) begin
          exp_q.delete();
          m_pc = flush_pc;
          m_st = ((m_st == ST_WAIT || m_st == ST_DROP) && !mem_valid) ? ST_DROP : ST_IDLE;
        end else begin
          if (dec_issue && exp_q.size() > 0) void'(exp_q.pop_front());
          case (m_st)
            ST_IDLE: if (exp_req) begin
              m_st = ST_WAIT;
              lat = LAT;
              resp_word = word_at(m_pc);
            end
            ST_WAIT: if (mem_valid) begin
              op = resp_word[6:0];
              exp_q.push_back({m_pc, resp_word, (op == 7'h6F)});
              if (op == 7'h6F) begin
                m_pc = m_pc + jal_off(resp_word);
                m_st = ST_IDLE;
              end else if (op == 7'h67) begin
                m_st = ST_STALL;
              end else begin
                m_pc = m_pc + 32'd4;
                m_st = ST_IDLE;
              end
            end
            ST_DROP: if (mem_valid) m_st = ST_IDLE;
            default: ;
          endcase
        end
      end
    end
    mem_hold = !rdy_in;
  endtask

  // Responder drives at the falling edge; the model samples 4 time units later.
  always begin
    @(negedge clk);
    if (!mem_hold) begin
      if (lat > 0) begin
        lat = lat - 1;
        mem_valid = (lat == 0);
        mem_inst  = (lat == 0) ? resp_word : 32'h0;
      end else begin
        mem_valid = 1'b0;
        mem_inst  = 32'h0;
      end
    end
    #4;
    sb_sample();
  end

  // ---------------- driver tasks ----------------
  task automatic do_flush(input logic [31:0] pc, input logic issue);
    @(negedge clk);
    flush_in  = 1'b1;
    flush_pc  = pc;
    dec_issue = issue;
    @(negedge clk);
    flush_in  = 1'b0;
    dec_issue = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    total++;
    if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_inst !== 32'h0 || dec_guess !== 1'b0) begin
      bad++; $display("FAIL reset_dec got=%b/%h/%h/%b exp=0/0/0/0", dec_valid, dec_pc, dec_inst, dec_guess);
    end
    total++;
    if (dbg_state !== ST_IDLE || dbg_count !== 5'd0 || mem_addr !== 32'h0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL reset_state got=%0d/%0d/%h/%b exp=0/0/0/0", dbg_state, dbg_count, mem_addr, mem_req);
    end
    @(negedge clk);
    rst_in = 1'b0;
    #4;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      bad++; $display("FAIL first_req got=%b/%h exp=1/00000000", mem_req, mem_addr);
    end
  endtask

  task automatic test_fill();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #4;
      if (dbg_count == 5'd16) found = 1'b1;
    end
    total++;
    if (found !== 1'b1) begin
      bad++; $display("FAIL fill_timeout got=%0d exp=16", dbg_count);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #4;
      total++;
      if (mem_req !== 1'b0) begin
        bad++; $display("FAIL fill_req_blocked got=%b exp=0", mem_req);
      end
    end
    total++;
    if (req_seen !== 16 || dec_pc !== 32'h0 || dec_guess !== 1'b0) begin
      bad++; $display("FAIL fill_reqs got=%0d/%h/%b exp=16/00000000/0", req_seen, dec_pc, dec_guess);
    end
  endtask

  task automatic test_drain();
    @(negedge clk);
    dec_issue = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      total++;
      if (dec_pc !== 32'(4 * i) || dec_inst !== NOP) begin
        bad++; $display("FAIL drain_seq got=%h/%h exp=%h/%h", dec_pc, dec_inst, 32'(4 * i), NOP);
      end
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    dec_issue = 1'b0;
  endtask

  task automatic test_jal();
    logic found;
    image[32'h10] = 32'h0080006F;
    image[32'h20] = 32'h00008067;
    do_flush(32'h10, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      #4;
      if (dec_valid === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (found !== 1'b1 || dec_pc !== 32'h10 || dec_inst !== 32'h0080006F || dec_guess !== 1'b1) begin
      bad++; $display("FAIL jal_entry got=%b/%h/%h/%b exp=1/00000010/0080006f/1", found, dec_pc, dec_inst, dec_guess);
    end
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h18) begin
      bad++; $display("FAIL jal_target got=%b/%h exp=1/00000018", mem_req, mem_addr);
    end
  endtask

  task automatic test_jalr();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #4;
      if (dbg_state == ST_STALL) found = 1'b1;
    end
    total++;
    if (found !== 1'b1) begin
      bad++; $display("FAIL jalr_stall got=%0d exp=%0d", dbg_state, ST_STALL);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #4;
      total++;
      if (mem_req !== 1'b0) begin
        bad++; $display("FAIL jalr_no_req got=%b exp=0", mem_req);
      end
    end
    total++;
    if (dbg_count !== 5'd4 || dec_pc !== 32'h10) begin
      bad++; $display("FAIL jalr_queue got=%0d/%h exp=4/00000010", dbg_count, dec_pc);
    end
    do_flush(32'h100, 1'b0);
    #4;
    total++;
    if (dec_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      bad++; $display("FAIL jalr_flush got=%b/%b/%h exp=0/1/00000100", dec_valid, mem_req, mem_addr);
    end
  endtask

  task automatic test_flush_wait();
    logic found;
    logic leaked;
    image[32'h108] = 32'hDEADBEEF;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #4;
      if (mem_req === 1'b1 && mem_addr == 32'h108) found = 1'b1;
    end
    total++;
    if (found !== 1'b1) begin
      bad++; $display("FAIL fw_req got=%h exp=00000108", mem_addr);
    end
    do_flush(32'h200, 1'b0);
    #4;
    total++;
    if (dbg_state !== ST_DROP || mem_req !== 1'b0) begin
      bad++; $display("FAIL fw_drop got=%0d/%b exp=%0d/0", dbg_state, mem_req, ST_DROP);
    end
    found  = 1'b0;
    leaked = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #4;
      if (dec_inst === 32'hDEADBEEF) leaked = 1'b1;
      if (mem_req === 1'b1) found = 1'b1;
    end
    total++;
    if (found !== 1'b1 || mem_addr !== 32'h200 || leaked !== 1'b0) begin
      bad++; $display("FAIL fw_restart got=%b/%h/%b exp=1/00000200/0", found, mem_addr, leaked);
    end
  endtask

  task automatic test_push_pop();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk); #4;
      if (dbg_count == 5'd3 && lat == 1 && mem_valid === 1'b0) found = 1'b1;
    end
    total++;
    if (found !== 1'b1) begin
      bad++; $display("FAIL pp_setup got=%0d exp=3", dbg_count);
    end
    @(negedge clk);
    dec_issue = 1'b1;
    @(negedge clk);
    dec_issue = 1'b0;
    #4;
    total++;
    if (dbg_count !== 5'd3 || dec_valid !== 1'b1 || dec_pc !== 32'h204) begin
      bad++; $display("FAIL pp_same_cycle got=%0d/%b/%h exp=3/1/00000204", dbg_count, dec_valid, dec_pc);
    end
  endtask

  task automatic test_flush_push_pop();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #4;
      if (lat == 1 && mem_valid === 1'b0 && dec_valid === 1'b1) found = 1'b1;
    end
    total++;
    if (found !== 1'b1) begin
      bad++; $display("FAIL fpp_setup got=%b exp=1", found);
    end
    do_flush(32'h300, 1'b1);
    #4;
    total++;
    if (dec_valid !== 1'b0 || dbg_count !== 5'd0 || mem_req !== 1'b1 || mem_addr !== 32'h300) begin
      bad++; $display("FAIL fpp_result got=%b/%0d/%b/%h exp=0/0/1/00000300", dec_valid, dbg_count, mem_req, mem_addr);
    end
  endtask

  task automatic test_branch();
    logic found;
    image[32'h308] = 32'h00000063;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #4;
      if (mem_req === 1'b1 && mem_addr == 32'h30C) found = 1'b1;
    end
    total++;
    if (found !== 1'b1) begin
      bad++; $display("FAIL br_not_taken got=%h exp=0000030c", mem_addr);
    end
    @(negedge clk);
    dec_issue = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dec_issue = 1'b0;
    #4;
    total++;
    if (dec_pc !== 32'h308 || dec_inst !== 32'h00000063 || dec_guess !== 1'b0) begin
      bad++; $display("FAIL br_entry got=%h/%h/%b exp=00000308/00000063/0", dec_pc, dec_inst, dec_guess);
    end
  endtask

  task automatic test_rdy_stall();
    logic        found;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_inst;
    logic [31:0] s_addr;
    logic [1:0]  s_state;
    logic [4:0]  s_count;
    @(negedge clk);
    dec_issue = 1'b1;
    repeat (7) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (mem_valid === 1'b0) found = 1'b1;
    end
    rdy_in = 1'b0;
    #3;
    s_valid = dec_valid; s_pc = dec_pc; s_inst = dec_inst;
    s_addr = mem_addr; s_state = dbg_state; s_count = dbg_count;
    total++;
    if (mem_req !== 1'b0 || found !== 1'b1) begin
      bad++; $display("FAIL rdy_first got=%b/%b exp=0/1", mem_req, found);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #4;
      total++;
      if (mem_req !== 1'b0 || dec_valid !== s_valid || dec_pc !== s_pc || dec_inst !== s_inst ||
          mem_addr !== s_addr || dbg_state !== s_state || dbg_count !== s_count) begin
        bad++;
        $display("FAIL rdy_hold got=%b/%b/%h/%h/%h/%0d/%0d exp=0/%b/%h/%h/%h/%0d/%0d",
                 mem_req, dec_valid, dec_pc, dec_inst, mem_addr, dbg_state, dbg_count,
                 s_valid, s_pc, s_inst, s_addr, s_state, s_count);
      end
    end
    @(negedge clk);
    rdy_in = 1'b1;
    repeat (20) @(negedge clk);
    dec_issue = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    flush_in  = 1'b0;
    flush_pc  = 32'h0;
    dec_issue = 1'b0;
    mem_valid = 1'b0;
    mem_inst  = 32'h0;
    test_reset();
    test_fill();
    test_drain();
    test_jal();
    test_jalr();
    test_flush_wait();
    test_push_pop();
    test_flush_push_pop();
    test_branch();
    test_rdy_stall();
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
